// File: rtl/perf_trace.sv
// Performance counters with programmable event selects plus a commit-trace FIFO.
// Counters add a per-cycle event delta; the trace path compacts committed lanes into a FWFT queue.
module perf_trace #(
    parameter int nevt = 12,
    parameter int ncnt = 8,
    parameter int cwd  = 2,
    parameter int tqsz = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [nevt-1:0][3:0]      evt_delta,
    input  logic                      cfg_we,
    input  logic [7:0]                cfg_addr,
    input  logic [63:0]               cfg_wdat,
    output logic [63:0]               cfg_rdat,
    input  logic [cwd-1:0]            com_valid,
    input  logic [cwd-1:0][63:0]      com_pcir,
    output logic                      trc_valid,
    output logic [63:0]               trc_data,
    input  logic                      trc_ready,
    output logic [$clog2(tqsz):0]     trc_level,
    output logic                      ovf_irq
);

    localparam int aw = $clog2(tqsz);
    localparam int lw = aw + 1;

    logic [63:0]     cnt       [ncnt];
    logic [7:0]      sel_evt   [ncnt];
    logic [ncnt-1:0] sel_en;
    logic [ncnt-1:0] sel_irqen;
    logic [ncnt-1:0] ovf;
    logic            tren;
    logic [63:0]     drop_cnt;
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   wr_ptr;
    logic [lw-1:0]   level;
    logic [63:0]     mem       [tqsz];

    logic [ncnt-1:0] cnt_we;
    logic [ncnt-1:0] sel_we;
    logic [ncnt-1:0] inc_en;
    logic [ncnt-1:0] ovf_set;
    logic [ncnt-1:0] ovf_clr;
    logic [64:0]     inc_sum   [ncnt];
    logic [3:0]      dsel      [ncnt];
    logic            ctrl_we;
    logic            flush;
    logic            pop;
    logic [cwd-1:0]  lane_acc;
    int              lane_off  [cwd];
    int              free_slots;
    int              acc_cnt;
    int              drop_n;
    logic [64:0]     drop_sum;

    always_comb begin
        for (int i = 0; i < ncnt; i++) begin
            cnt_we[i] = cfg_we && (cfg_addr == 8'(i));
            sel_we[i] = cfg_we && (cfg_addr == 8'(32 + i));
            dsel[i]   = 4'd0;
            for (int j = 0; j < nevt; j++) begin
                if (sel_evt[i] == 8'(j)) dsel[i] = evt_delta[j];
            end
            inc_en[i]  = sel_en[i] && (int'(sel_evt[i]) < nevt);
            inc_sum[i] = {1'b0, cnt[i]} + {61'd0, dsel[i]};
            // A config write to the counter replaces the increment, so it cannot overflow.
            ovf_set[i] = inc_en[i] && !cnt_we[i] && inc_sum[i][64];
        end
        ovf_clr = (cfg_we && cfg_addr == 8'h40) ? cfg_wdat[ncnt-1:0] : '0;
        ctrl_we = cfg_we && (cfg_addr == 8'h41);
        flush   = ctrl_we && cfg_wdat[1];
    end

    assign trc_valid = (level != '0);
    assign pop       = trc_valid && trc_ready;

    // Lanes are packed in ascending order; only the first free_slots valid lanes fit.
    always_comb begin
        free_slots = tqsz - int'(level) + (pop ? 1 : 0);
        acc_cnt    = 0;
        drop_n     = 0;
        for (int i = 0; i < cwd; i++) begin
            lane_off[i] = acc_cnt + drop_n;
            lane_acc[i] = 1'b0;
            if (tren && com_valid[i]) begin
                if (lane_off[i] < free_slots) begin
                    lane_acc[i] = 1'b1;
                    acc_cnt     = acc_cnt + 1;
                end else begin
                    drop_n = drop_n + 1;
                end
            end
        end
        drop_sum = {1'b0, drop_cnt} + 65'(drop_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ncnt; i++) begin
                cnt[i]     <= '0;
                sel_evt[i] <= '0;
            end
            sel_en    <= '0;
            sel_irqen <= '0;
            ovf       <= '0;
            tren      <= 1'b0;
            drop_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
        end else begin
            for (int i = 0; i < ncnt; i++) begin
                if (cnt_we[i])      cnt[i] <= cfg_wdat;
                else if (inc_en[i]) cnt[i] <= inc_sum[i][63:0];
                if (sel_we[i]) begin
                    sel_en[i]    <= cfg_wdat[63];
                    sel_irqen[i] <= cfg_wdat[62];
                    sel_evt[i]   <= cfg_wdat[7:0];
                end
            end
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            if (ctrl_we) tren <= cfg_wdat[0];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                wr_ptr <= wr_ptr + aw'(acc_cnt);
                level  <= lw'(int'(level) + acc_cnt - (pop ? 1 : 0));
                if (drop_n != 0) drop_cnt <= drop_sum[64] ? '1 : drop_sum[63:0];
            end
        end
    end

    // Storage needs no reset: the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < cwd; i++) begin
            if (lane_acc[i] && !flush) mem[wr_ptr + aw'(lane_off[i])] <= com_pcir[i];
        end
    end

    always_comb begin
        cfg_rdat = '0;
        for (int i = 0; i < ncnt; i++) begin
            if (cfg_addr == 8'(i))      cfg_rdat = cnt[i];
            if (cfg_addr == 8'(32 + i)) cfg_rdat = {sel_en[i], sel_irqen[i], 54'd0, sel_evt[i]};
        end
        if (cfg_addr == 8'h40) cfg_rdat = 64'(ovf);
        if (cfg_addr == 8'h41) cfg_rdat = {63'd0, tren};
        if (cfg_addr == 8'h42) cfg_rdat = drop_cnt;
    end

    assign trc_data  = trc_valid ? mem[rd_ptr] : '0;
    assign trc_level = level;
    assign ovf_irq   = |(ovf & sel_irqen);

endmodule

// File: tb/tb_perf_trace.sv
// Self-checking bench for perf_trace: counter/overflow register checks and a
// scoreboarded trace FIFO with drop accounting, flush and async reset.
module tb_perf_trace;

    localparam int nevt = 12;
    localparam int ncnt = 8;
    localparam int cwd  = 2;
    localparam int tqsz = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [nevt-1:0][3:0] evt_delta = '0;
    logic                 cfg_we = 1'b0;
    logic [7:0]           cfg_addr = '0;
    logic [63:0]          cfg_wdat = '0;
    logic [63:0]          cfg_rdat;
    logic [cwd-1:0]       com_valid = '0;
    logic [cwd-1:0][63:0] com_pcir = '0;
    logic                 trc_valid;
    logic [63:0]          trc_data;
    logic                 trc_ready = 1'b0;
    logic [4:0]           trc_level;
    logic                 ovf_irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic        m_tren   = 1'b0;
    logic [63:0] m_drop   = '0;
    logic [31:0] pc_ctr   = 32'h1000;
    logic [63:0] m_cnt1;
    logic [63:0] first_word;

    perf_trace #(.nevt(nevt), .ncnt(ncnt), .cwd(cwd), .tqsz(tqsz)) dut (
        .clk(clk), .rst(rst), .evt_delta(evt_delta),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdat(cfg_wdat), .cfg_rdat(cfg_rdat),
        .com_valid(com_valid), .com_pcir(com_pcir),
        .trc_valid(trc_valid), .trc_data(trc_data), .trc_ready(trc_ready),
        .trc_level(trc_level), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [63:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_wdat = d;
        step();
        cfg_we   = 1'b0;
        cfg_wdat = '0;
    endtask

    task automatic cfg_check(input string tag, input logic [7:0] a, input logic [63:0] e);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdat, e);
    endtask

    // One trace cycle: drive lanes/ready (optionally a flush), update the model, compare pops.
    task automatic trace_cycle(input logic [1:0] v, input logic rdy, input logic do_flush);
        logic [63:0] w [cwd];
        int free;
        logic pop;
        for (int i = 0; i < cwd; i++) begin
            w[i]   = {pc_ctr, $urandom()};
            pc_ctr = pc_ctr + 32'd4;
            com_pcir[i] = w[i];
        end
        com_valid = v;
        trc_ready = rdy;
        if (do_flush) begin
            cfg_we   = 1'b1;
            cfg_addr = 8'h41;
            cfg_wdat = 64'h3;
        end
        pop = (exp_q.size() > 0) && rdy;
        if (do_flush) begin
            exp_q.delete();
            m_tren = 1'b1;
        end else begin
            if (pop) begin
                check("trc_valid_on_pop", {63'd0, trc_valid}, 64'd1);
                check("trc_data", trc_data, exp_q.pop_front());
            end
            free = tqsz - (exp_q.size() + (pop ? 1 : 0)) + (pop ? 1 : 0);
            for (int i = 0; i < cwd; i++) begin
                if (v[i] && m_tren) begin
                    if (free > 0) begin
                        exp_q.push_back(w[i]);
                        free--;
                    end else begin
                        m_drop = m_drop + 64'd1;
                    end
                end
            end
        end
        step();
        com_valid = '0;
        trc_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_wdat  = '0;
        check("trc_level", 64'(trc_level), 64'(exp_q.size()));
    endtask

    task automatic drain_to(input int target);
        for (int k = 0; k < 100 && exp_q.size() > target; k++) trace_cycle(2'b00, 1'b1, 1'b0);
        check("drain_reached", 64'(exp_q.size()), 64'(target));
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_trc_valid", {63'd0, trc_valid}, 64'd0);
        check("rst_trc_level", 64'(trc_level), 64'd0);
        check("rst_ovf_irq", {63'd0, ovf_irq}, 64'd0);
        check("rst_trc_data", trc_data, 64'd0);
        cfg_check("rst_cnt0", 8'h00, 64'd0);
        cfg_check("rst_sel0", 8'h20, 64'd0);
        cfg_check("rst_ovf", 8'h40, 64'd0);
        cfg_check("rst_ctrl", 8'h41, 64'd0);
        cfg_check("rst_drop", 8'h42, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Cycle counting on event 1, then hold with sel=0.
        cfg_write(8'h20, 64'h8000_0000_0000_0001);
        cfg_check("sel0_readback", 8'h20, 64'h8000_0000_0000_0001);
        evt_delta[1] = 4'd1;
        repeat (10) step();
        evt_delta = '0;
        cfg_check("cnt0_ten", 8'h00, 64'd10);
        cfg_write(8'h20, 64'h8000_0000_0000_0000);
        evt_delta[1] = 4'd1;
        repeat (5) step();
        evt_delta = '0;
        cfg_check("cnt0_hold_sel0", 8'h00, 64'd10);

        // Random deltas; out-of-range select and disabled counter must hold.
        cfg_write(8'h21, 64'h8000_0000_0000_0003);
        cfg_write(8'h23, 64'h8000_0000_0000_00C8);
        cfg_write(8'h24, 64'h0000_0000_0000_0003);
        m_cnt1 = '0;
        for (int k = 0; k < 20; k++) begin
            for (int j = 1; j < nevt; j++) evt_delta[j] = 4'($urandom_range(0, 15));
            m_cnt1 = m_cnt1 + 64'(evt_delta[3]);
            step();
        end
        evt_delta = '0;
        cfg_check("cnt1_random", 8'h01, m_cnt1);
        cfg_check("cnt3_sel_oob", 8'h03, 64'd0);
        cfg_check("cnt4_disabled", 8'h04, 64'd0);
        evt_delta[3] = 4'd5;
        cfg_write(8'h01, 64'd100);
        evt_delta = '0;
        cfg_check("cnt1_write_override", 8'h01, 64'd100);

        // Wrap with overflow and interrupt, then W1C.
        cfg_write(8'h02, 64'hFFFF_FFFF_FFFF_FFFE);
        cfg_write(8'h22, 64'hC000_0000_0000_0005);
        evt_delta[5] = 4'd3;
        step();
        evt_delta = '0;
        cfg_check("cnt2_wrap", 8'h02, 64'd1);
        cfg_check("ovf_set", 8'h40, 64'd4);
        check("ovf_irq_set", {63'd0, ovf_irq}, 64'd1);
        cfg_write(8'h40, 64'd4);
        cfg_check("ovf_w1c", 8'h40, 64'd0);
        check("ovf_irq_clr", {63'd0, ovf_irq}, 64'd0);

        // Overflow set and clear in the same cycle: set wins.
        cfg_write(8'h02, 64'hFFFF_FFFF_FFFF_FFFF);
        evt_delta[5] = 4'd1;
        cfg_write(8'h40, 64'd4);
        evt_delta = '0;
        cfg_check("ovf_set_wins", 8'h40, 64'd4);
        cfg_check("cnt2_wrap_zero", 8'h02, 64'd0);
        check("ovf_irq_set_wins", {63'd0, ovf_irq}, 64'd1);
        cfg_write(8'h40, 64'd4);
        check("ovf_irq_clr2", {63'd0, ovf_irq}, 64'd0);

        // Fill with both lanes for 9 cycles: 16 stored, 2 dropped.
        cfg_write(8'h41, 64'd1);
        m_tren = 1'b1;
        first_word = {pc_ctr, 32'd0};
        trace_cycle(2'b11, 1'b0, 1'b0);
        first_word = exp_q[0];
        repeat (8) trace_cycle(2'b11, 1'b0, 1'b0);
        check("full_level", 64'(trc_level), 64'd16);
        check("full_head", trc_data, first_word);
        cfg_check("drop_two", 8'h42, 64'd2);

        // Full with a pop: one lane taken, one dropped.
        trace_cycle(2'b11, 1'b1, 1'b0);
        check("full_pop_level", 64'(trc_level), 64'd16);
        cfg_check("drop_three", 8'h42, 64'd3);

        for (int k = 0; k < 40; k++)
            trace_cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        cfg_check("drop_random", 8'h42, m_drop);

        // Flush at level 5 beats same-cycle push and pop.
        drain_to(5);
        trace_cycle(2'b11, 1'b1, 1'b1);
        check("flush_level", 64'(trc_level), 64'd0);
        check("flush_valid", {63'd0, trc_valid}, 64'd0);
        cfg_check("ctrl_readback", 8'h41, 64'd1);

        // tren=0 stops pushes without counting drops; existing contents still drain.
        repeat (3) trace_cycle(2'b11, 1'b0, 1'b0);
        cfg_write(8'h41, 64'd0);
        m_tren = 1'b0;
        repeat (3) trace_cycle(2'b11, 1'b0, 1'b0);
        check("tren_off_level", 64'(trc_level), 64'd6);
        cfg_check("tren_off_drop", 8'h42, m_drop);
        drain_to(0);

        // Async reset with level 7 and nonzero counters.
        cfg_write(8'h41, 64'd1);
        m_tren = 1'b1;
        repeat (3) trace_cycle(2'b11, 1'b0, 1'b0);
        trace_cycle(2'b01, 1'b0, 1'b0);
        check("pre_rst_level", 64'(trc_level), 64'd7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cfg_addr = 8'h00;
        #1;
        check("arst_level", 64'(trc_level), 64'd0);
        check("arst_valid", {63'd0, trc_valid}, 64'd0);
        check("arst_data", trc_data, 64'd0);
        check("arst_cnt0", cfg_rdat, 64'd0);
        cfg_check("arst_cnt1", 8'h01, 64'd0);
        cfg_check("arst_sel0", 8'h21, 64'd0);
        cfg_check("arst_drop", 8'h42, 64'd0);
        cfg_check("arst_ctrl", 8'h41, 64'd0);
        repeat (2) step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_trace.md
PERF_TRACE -- requirements
Module: perf_trace

Interface
REQ-001 SHALL have parameter nevt, default 12: number of event inputs; event 0 is "no event", event 1 is "cycle".
REQ-002 SHALL have parameter ncnt, default 8: number of programmable 64-bit counters (1..32).
REQ-003 SHALL have parameter cwd, default 2: commit lanes traced per cycle.
REQ-004 SHALL have parameter tqsz, default 16: trace FIFO depth (power of two, at least 2).
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 evt_delta  input  nevt x 4: per-event unsigned increment for the current cycle.
REQ-008 cfg_we  input  1: configuration write strobe.
REQ-009 cfg_addr  input  8: configuration register address (write and read).
REQ-010 cfg_wdat  input  64: configuration write data.
REQ-011 cfg_rdat  output  64: combinational read of cfg_addr; unmapped addresses read 0.
REQ-012 com_valid  input  cwd: lane i carries a committed instruction.
REQ-013 com_pcir  input  cwd x 64: lane i trace word {pc[31:0], ir[31:0]}.
REQ-014 trc_valid  output  1: trace FIFO non-empty.
REQ-015 trc_data  output  64: FIFO head (first-word-fall-through).
REQ-016 trc_ready  input  1: consumer accepts head.
REQ-017 trc_level  output  $clog2(tqsz)+1: current FIFO occupancy.
REQ-018 ovf_irq  output  1: OR over counters of (ovf[i] & irqen[i]), from registered state only.

Function
REQ-019 Address map: 0x00+i = counter i; 0x20+i = select i {bit63 en, bit62 irqen, bits7:0 sel}; 0x40 = overflow status (write-1-to-clear); 0x41 = trace ctrl {bit0 tren, bit1 flush}; 0x42 = drop count (read-only).
REQ-020 Each cycle, for counter i with en=1 and sel<nevt: cnt[i] <= cnt[i] + evt_delta[sel]; sel>=nevt or en=0 holds the value.
REQ-021 Increment SHALL wrap modulo 2^64 and set ovf[i] on carry-out; ovf bits are sticky until cleared.
REQ-022 cfg write to counter i SHALL override that cycle's increment; write value visible next cycle.
REQ-023 Same-cycle overflow set and W1C clear of one bit: set wins.
REQ-024 Write to 0x41 with bit1=1 SHALL empty the FIFO (level 0 next cycle) and stores tren from bit0; flush beats same-cycle push and pop; bit1 reads back 0.
REQ-025 Pop occurs when trc_valid & trc_ready; no pop when empty.
REQ-026 When tren=1, valid lanes are pushed compacted, in ascending lane order, in one cycle.
REQ-027 Free space for push = tqsz - trc_level + (pop this cycle ? 1 : 0).
REQ-028 If valid lanes exceed free space, the first lanes up to free space are accepted; the rest are dropped and drop count is increased by the number dropped, saturating at 2^64-1.
REQ-029 Block SHALL never back-pressure commit; com inputs have no ready.
REQ-030 Read/write pointers wrap modulo tqsz; trc_level is exact in 0..tqsz.
REQ-031 Clearing tren SHALL stop pushes only; contents remain drainable.

Reset
REQ-032 On rst: all counters, selects, ovf, drop count, tren and pointers 0; trc_valid=0, trc_level=0, ovf_irq=0, trc_data=0.
REQ-033 Reset asserted mid-operation SHALL discard FIFO contents and counter values immediately, without waiting for a clock edge.

Verification
REQ-034 Select 0x20 <- bit63|1, evt_delta[1]=1 for 10 cycles -> counter 0 reads 10; with sel=0 -> stays 10.
REQ-035 Counter 2 <- 0xFFFF_FFFF_FFFF_FFFE, select en|irqen|sel=5, evt_delta[5]=3 one cycle -> counter 2 = 1, ovf bit 2 = 1, ovf_irq=1; W1C 0x40 <- 4 -> ovf_irq=0.
REQ-036 tren=1, trc_ready=0, both lanes valid for 9 cycles, tqsz=16 -> level 16, drop count 2, trc_data = first lane-0 word.
REQ-037 FIFO full, trc_ready=1, lanes {1,1} -> one accepted, one dropped, level stays 16.
REQ-038 Level 5, write 0x41 <- 3 with push and pop active -> level 0 next cycle, trc_valid=0.
REQ-039 Reset asserted with level 7 and counters nonzero -> trc_level=0, all cfg_rdat reads 0, before the next clock edge.
